// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle,
// sign fix-up in a final cycle, results land in HI/LO with a one-cycle done pulse.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum, rem_sh, diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               dz;

   always_comb begin
      sign_a = ~op[0] & src_a[WIDTH-1];
      sign_b = ~op[0] & src_b[WIDTH-1];
      a_mag  = sign_a ? -src_a : src_a;
      b_mag  = sign_b ? -src_b : src_b;

      // Multiply: add multiplier into the upper half when the low bit is set, then shift right.
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
      mul_nxt = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

      // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
      rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, b_q};
      div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod_fix = neg_q  ? -acc_q : acc_q;
      quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      // A zero divisor leaves the dividend magnitude as remainder, so sign fix-up restores src_a.
      dz       = div_q && (b_q == '0);

      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      b_d     = b_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               state_d = RUN;
               cnt_d   = CW'(WIDTH-1);
               div_d   = op[1];
               neg_d   = sign_a ^ sign_b;
               rneg_d  = sign_a;
               b_d     = b_mag;
               acc_d   = {{WIDTH{1'b0}}, a_mag};
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = div_q ? div_nxt : mul_nxt;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               dz_d   = dz;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = dz ? {WIDTH{1'b1}} : quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         b_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with cycle-accurate handshake,
// checked every cycle, plus literal checks of the documented corner cases.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference result: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
   function automatic logic [2*W:0] ref_calc(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      longint       sa, sb;
      logic [63:0]  ua, ub, p;
      logic         z;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      z  = 1'b0;
      p  = '0;
      case (o)
         2'd0: p = 64'(sa * sb);
         2'd1: p = ua * ub;
         2'd2: if (b == '0) begin p = {a, {W{1'b1}}}; z = 1'b1; end
               else p = {W'(sa % sb), W'(sa / sb)};
         default: if (b == '0) begin p = {a, {W{1'b1}}}; z = 1'b1; end
               else p = {W'(ua % ub), W'(ua / ub)};
      endcase
      return {z, p};
   endfunction

   // Model: an accepted op stays busy for W+1 cycles, then the result appears with done.
   int             m_rem = 0;
   logic           m_done = 1'b0, m_dz = 1'b0;
   logic [W-1:0]   m_hi = '0, m_lo = '0;
   logic [2*W:0]   m_pend = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rem = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
      end else begin
         m_done = 1'b0;
         m_dz   = 1'b0;
         if (m_rem > 0) begin
            if (flush) m_rem = 0;
            else begin
               m_rem--;
               if (m_rem == 0) begin
                  m_done = 1'b1;
                  m_dz   = m_pend[2*W];
                  m_hi   = m_pend[2*W-1:W];
                  m_lo   = m_pend[W-1:0];
               end
            end
         end else if (start && !flush) begin
            m_rem  = W + 1;
            m_pend = ref_calc(op, src_a, src_b);
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(m_rem > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #2;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = n; break; end
      end
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done within 60 cycles");
      end
   endtask

   task automatic run_lit(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz);
      int lat;
      issue(o, a, b);
      wait_done(lat);
      chk({name, "_latency"}, 64'(lat), 64'(W + 2));
      chk({name, "_hi"}, 64'(hi), 64'(eh));
      chk({name, "_lo"}, 64'(lo), 64'(el));
      chk({name, "_dz"}, 64'(div_by_zero), 64'(edz));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'd1;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int lat, ndone;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      @(posedge clk); #2 reset_n = 1'b1;

      run_lit("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_lit("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_lit("mult_minxmin", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      run_lit("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

      // Issue DIVU in the done cycle of the previous DIV.
      start = 1'b1; op = 2'd3; src_a = 32'd7; src_b = 32'd2;
      @(posedge clk); #2 start = 1'b0;
      wait_done(lat);
      chk("b2b_latency", 64'(lat), 64'(W + 2));
      chk("b2b_hi", 64'(hi), 64'd1);
      chk("b2b_lo", 64'(lo), 64'd3);

      run_lit("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_lit("divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_lit("div_neg_by0", 2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
      run_lit("divu_setup", 2'd3, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0);

      // Flush in RUN cycle 10.
      issue(2'd1, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #2 flush = 1'b1;
      @(posedge clk); #2 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 64'(busy), 64'd0);
      ndone = 0;
      repeat (40) begin @(negedge clk); if (done) ndone++; end
      chk("flush_no_done", 64'(ndone), 64'd0);
      chk("flush_hi", 64'(hi), 64'h11);
      chk("flush_lo", 64'(lo), 64'h22);

      // Start while busy must be ignored.
      issue(2'd1, 32'd3, 32'd4);
      repeat (5) @(posedge clk);
      #2 start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd2;
      @(posedge clk); #2 start = 1'b0;
      ndone = 0;
      repeat (60) begin @(negedge clk); if (done) ndone++; end
      chk("busy_start_ndone", 64'(ndone), 64'd1);
      chk("busy_start_lo", 64'(lo), 64'd12);
      chk("busy_start_hi", 64'(hi), 64'd0);

      // Asynchronous reset mid-divide.
      issue(2'd2, 32'd100, 32'd7);
      repeat (19) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      chk("arst_hi", 64'(hi), 64'd0);
      @(posedge clk); #2 reset_n = 1'b1;
      run_lit("after_rst", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

      // Random traffic: starts at any time (ignored while busy), rare flushes.
      repeat (2000) begin
         @(posedge clk); #2;
         start = ($urandom_range(0, 3) == 0);
         op    = 2'($urandom);
         src_a = pick();
         src_b = pick();
         flush = ($urandom_range(0, 99) == 0);
      end
      @(posedge clk); #2 start = 1'b0; flush = 1'b0;
      repeat (40) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the EX stage. Successor to the single-cycle ALU decode path: takes MULT/MULTU/DIV/DIVU out of the combinational ALU.
- Result width is parametrised. Results are written to architectural HI/LO registers.
- Exposes a start/busy/done handshake that the hazard unit uses to stall the pipeline, plus a flush input for squashed instructions.

Parameters:
- WIDTH, 32, operand width and HI/LO width; legal values are even and >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- flush  in  1  abort the current or requested operation.
- busy  out  1  operation in progress; the hazard unit stalls on busy.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.
- div_by_zero  out  1  pulses together with done when a DIV/DIVU had src_b == 0.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - State = IDLE.
  - hi = lo = 0; busy = done = div_by_zero = 0; internal counter = 0.
  - Reset mid-operation discards that operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 and flush=0 at the edge ending cycle t:
    - Latch op.
    - For signed ops, latch the operand magnitudes and the result sign bits (quotient sign = sign_a XOR sign_b; remainder sign = sign_a).
    - Load counter = WIDTH-1 and go to RUN.
  - start=1 with flush=1: no operation is accepted.
- RUN:
  - Cycles t+1 .. t+WIDTH; one iteration per cycle; counter decrements.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
  - Leave RUN for FIX when counter == 0 at the edge.
- FIX:
  - Cycle t+WIDTH+1.
  - Apply two's-complement sign correction to the result.
  - Write hi/lo at the edge ending this cycle, then go to IDLE.
- Handshake and timing:
  - busy = 1 in RUN and FIX, i.e. cycles t+1 .. t+WIDTH+1.
  - done = 1 only in cycle t+WIDTH+2, registered and aligned with the new hi/lo.
  - Total latency from start to done is WIDTH+2 cycles (34 for WIDTH=32).
  - A new start may coincide with the done cycle; back-to-back operations are allowed.
- start while busy is ignored. It is the hazard unit's duty to hold the instruction.
- flush while busy: return to IDLE at the next edge. hi/lo keep their previous values; no done, no div_by_zero.
- Multiply results:
  - Full 2*WIDTH product: hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Signed product is exact for all inputs, including most-negative × most-negative.
- Divide results:
  - Quotient truncates toward zero; remainder carries the sign of the dividend.
  - Signed overflow case (most-negative / -1): lo = most-negative, hi = 0. This is the natural mod-2^WIDTH result; no special path is needed.
- Divide by zero:
  - Full latency still applies.
  - lo = all ones, hi = src_a (raw value, unsigned and signed alike).
  - div_by_zero = 1 during the done cycle.
- hi/lo change only at the FIX->IDLE edge or on reset.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle t -> busy high t+1..t+33; done at t+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) × 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 issued in the done cycle of the DIV -> accepted; lo=3, hi=1 after 34 more cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, div_by_zero pulses with done.
- Start MULTU 3×4 with hi/lo=0x11/0x22 from a prior op; flush at RUN cycle 10 -> busy low next cycle; no done for 40 cycles; hi/lo remain 0x11/0x22. A start pulsed while busy is ignored: no extra done.
- Drive reset_n low asynchronously at cycle t+20 of a DIV -> outputs are 0 immediately; after release, a new MULTU 2×3 completes with lo=6 after 34 cycles.
